// File: rtl/card_pkg.sv
// Shared constants, card decode helpers and FSM state type for the card dealer.
package card_pkg;

  localparam int unsigned DeckSizeDefault = 52;
  localparam int unsigned CardWDefault    = 6;
  localparam int unsigned RngLatDefault   = 2;
  localparam int unsigned RanksPerSuit    = 13;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    REQ,
    WAIT,
    SWAP
  } dealer_state_e;

  function automatic int unsigned card_suit(input int unsigned code);
    return code / RanksPerSuit;
  endfunction

  function automatic int unsigned card_rank(input int unsigned code);
    return code % RanksPerSuit;
  endfunction

endpackage

// File: rtl/deck_store.sv
// Deck register file: two combinational read ports, one synchronous write port, no reset.
module deck_store #(
  parameter int unsigned DEPTH = 52,
  parameter int unsigned WIDTH = 6
) (
  input  logic             clock,
  input  logic [WIDTH-1:0] rd_idx,
  input  logic [WIDTH-1:0] rd_top,
  output logic [WIDTH-1:0] idx_data,
  output logic [WIDTH-1:0] top_data,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign idx_data = mem[rd_idx];
  assign top_data = mem[rd_top];

  // Single write port; contents are established by the INIT sweep, not by reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/card_dealer.sv
// Deals cards without repetition using a swap-and-shrink draw driven by an external RNG.
module card_dealer
  import card_pkg::*;
#(
  parameter int unsigned DECK_SIZE = DeckSizeDefault,
  parameter int unsigned CARD_W    = CardWDefault,
  parameter int unsigned RNG_LAT   = RngLatDefault
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              shuffle_start,
  input  logic              deal_req,
  input  logic [15:0]       rng_int,
  output logic              rng_next,
  output logic [15:0]       rng_max,
  output logic              deal_valid,
  output logic [CARD_W-1:0] card,
  output logic [CARD_W-1:0] cards_left,
  output logic              empty,
  output logic              busy
);

  localparam int unsigned WaitW = (RNG_LAT > 1) ? $clog2(RNG_LAT) : 1;

  dealer_state_e     state_q, state_d;
  logic [CARD_W-1:0] init_q, init_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [CARD_W-1:0] left_d;
  logic [CARD_W-1:0] card_d;
  logic              valid_d;

  logic [CARD_W-1:0] idx, top, idx_card, top_card;
  logic              we;
  logic [CARD_W-1:0] waddr, wdata;

  assign rng_max = 16'(cards_left);
  assign top     = cards_left - 1'b1;
  // Out-of-range RNG values fall back to the top card rather than reading a dead slot.
  assign idx     = (rng_int < 16'(cards_left)) ? rng_int[CARD_W-1:0] : top;

  deck_store #(
    .DEPTH (DECK_SIZE),
    .WIDTH (CARD_W)
  ) u_deck_store (
    .clock    (clock),
    .rd_idx   (idx),
    .rd_top   (top),
    .idx_data (idx_card),
    .top_data (top_card),
    .wr_en    (we),
    .wr_addr  (waddr),
    .wr_data  (wdata)
  );

  // Next-state, deck write and output next values; shuffle_start overrides everything.
  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    wait_d  = wait_q;
    left_d  = cards_left;
    card_d  = card;
    valid_d = 1'b0;
    we      = 1'b0;
    waddr   = idx;
    wdata   = top_card;
    if (shuffle_start) begin
      state_d = INIT;
      init_d  = '0;
      left_d  = '0;
    end else begin
      unique case (state_q)
        INIT: begin
          we    = 1'b1;
          waddr = init_q;
          wdata = init_q;
          if (init_q == CARD_W'(DECK_SIZE - 1)) begin
            state_d = IDLE;
            left_d  = CARD_W'(DECK_SIZE);
          end else begin
            init_d = init_q + 1'b1;
          end
        end
        IDLE: begin
          if (deal_req && (cards_left != '0)) begin
            state_d = REQ;
          end
        end
        REQ: begin
          wait_d  = '0;
          state_d = (RNG_LAT == 0) ? SWAP : WAIT;
        end
        WAIT: begin
          if (32'(wait_q) == RNG_LAT - 1) begin
            state_d = SWAP;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        SWAP: begin
          // Dealt slot is refilled with the top card; idx == top is a harmless self-write.
          we      = 1'b1;
          card_d  = idx_card;
          left_d  = cards_left - 1'b1;
          valid_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = INIT;
      endcase
    end
  end

  // State and registered outputs; flags are derived from next values so they track the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= INIT;
      init_q     <= '0;
      wait_q     <= '0;
      cards_left <= '0;
      card       <= '0;
      deal_valid <= 1'b0;
      rng_next   <= 1'b0;
      empty      <= 1'b1;
      busy       <= 1'b1;
    end else begin
      state_q    <= state_d;
      init_q     <= init_d;
      wait_q     <= wait_d;
      cards_left <= left_d;
      card       <= card_d;
      deal_valid <= valid_d;
      rng_next   <= (state_d == REQ);
      empty      <= (left_d == '0);
      busy       <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer against a behavioural deck model.
module tb_card_dealer;

  localparam int DECK = 52;
  localparam int LAT  = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        shuffle_start;
  logic        deal_req;
  logic [15:0] rng_int;
  logic        rng_next;
  logic [15:0] rng_max;
  logic        deal_valid;
  logic [5:0]  card;
  logic [5:0]  cards_left;
  logic        empty;
  logic        busy;

  int checks = 0;
  int passes = 0;

  // Behavioural deck: live cards in m_deck[0..m_left-1].
  int m_deck [DECK];
  int m_left;

  card_dealer #(
    .DECK_SIZE (DECK),
    .CARD_W    (6),
    .RNG_LAT   (LAT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .shuffle_start (shuffle_start),
    .deal_req      (deal_req),
    .rng_int       (rng_int),
    .rng_next      (rng_next),
    .rng_max       (rng_max),
    .deal_valid    (deal_valid),
    .card          (card),
    .cards_left    (cards_left),
    .empty         (empty),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_fill();
    for (int i = 0; i < DECK; i++) m_deck[i] = i;
    m_left = DECK;
  endtask

  // Returns the card the model deals for RNG value r, and shrinks the model deck.
  function automatic int model_draw(input int r);
    int k, c;
    k = (r < m_left) ? r : m_left - 1;
    c = m_deck[k];
    m_deck[k] = m_deck[m_left - 1];
    m_left--;
    return c;
  endfunction

  // Counts edges until busy falls, checking INIT is quiet; expects exactly DECK edges.
  task automatic wait_init(input string tag);
    int n = 0;
    int noise = 0;
    int nonzero = 0;
    while (busy && n < 200) begin
      tick();
      n++;
      if (rng_next || deal_valid) noise++;
      if (busy && cards_left != 0) nonzero++;
    end
    checks++;
    if (n !== DECK) $display("FAIL %s init_edges got %0d want %0d", tag, n, DECK);
    else passes++;
    checks++;
    if (noise !== 0) $display("FAIL %s init_pulses got %0d want 0", tag, noise);
    else passes++;
    checks++;
    if (nonzero !== 0) $display("FAIL %s init_left_nonzero got %0d want 0", tag, nonzero);
    else passes++;
    checks++;
    if (cards_left !== 6'(DECK) || empty !== 1'b0)
      $display("FAIL %s post_init left=%0d empty=%0b want %0d/0", tag, cards_left, empty, DECK);
    else passes++;
    model_fill();
  endtask

  // One isolated deal with a fixed RNG value; checks pulse, latency, card and count.
  task automatic do_deal(input int r, input string tag);
    int exp_card, n, pulses, bad_max;
    exp_card = model_draw(r);
    rng_int  = 16'(r);
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    n = 0;
    pulses = rng_next ? 1 : 0;
    bad_max = 0;
    while (!deal_valid && n < 12) begin
      if (rng_max !== 16'(m_left + 1)) bad_max++;
      tick();
      n++;
      if (rng_next) pulses++;
    end
    checks++;
    if (n !== LAT + 2) $display("FAIL %s latency got %0d want %0d", tag, n, LAT + 2);
    else passes++;
    checks++;
    if (pulses !== 1) $display("FAIL %s rng_next_pulses got %0d want 1", tag, pulses);
    else passes++;
    checks++;
    if (bad_max !== 0) $display("FAIL %s rng_max_unstable got %0d want 0", tag, bad_max);
    else passes++;
    checks++;
    if (card !== 6'(exp_card) || cards_left !== 6'(m_left))
      $display("FAIL %s card=%0d left=%0d want %0d/%0d", tag, card, cards_left, exp_card, m_left);
    else passes++;
    tick();
    checks++;
    if (deal_valid !== 1'b0 || card !== 6'(exp_card) || busy !== 1'b0)
      $display("FAIL %s after_valid v=%0b card=%0d busy=%0b want 0/%0d/0", tag, deal_valid,
               card, busy, exp_card);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    shuffle_start = 1'b0;
    deal_req = 1'b0;
    rng_int = '0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || empty !== 1'b1 || cards_left !== 6'd0 || card !== 6'd0 ||
        deal_valid !== 1'b0 || rng_next !== 1'b0)
      $display("FAIL reset_values busy=%0b empty=%0b left=%0d card=%0d v=%0b nx=%0b want 1/1/0/0/0/0",
               busy, empty, cards_left, card, deal_valid, rng_next);
    else passes++;
    reset = 1'b0;
    wait_init("reset");
  endtask

  task automatic test_fixed_deal();
    do_deal(5, "deal_r5_first");
    do_deal(5, "deal_r5_second");
    do_deal(60, "deal_clamp");
  endtask

  // Full deck with deal_req held high; RNG model answers each rng_next pulse.
  task automatic test_back_to_back();
    int seen [DECK];
    int exp_card, dealt, r, bad_card, bad_max, cyc, dup;
    int noise;
    model_fill();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    wait_init("b2b_init");
    for (int i = 0; i < DECK; i++) seen[i] = 0;
    dealt = 0; bad_card = 0; bad_max = 0; cyc = 0; exp_card = -1;
    deal_req = 1'b1;
    while (dealt < DECK && cyc < DECK * 10) begin
      tick();
      cyc++;
      if (rng_next) begin
        if (rng_max !== 16'(m_left)) bad_max++;
        r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(m_left, 65535)) :
                                          int'($urandom_range(0, m_left - 1));
        rng_int = 16'(r);
        exp_card = model_draw(r);
      end
      if (deal_valid) begin
        dealt++;
        if (card !== 6'(exp_card) || cards_left !== 6'(m_left)) bad_card++;
        if (card < DECK) seen[card]++;
      end
    end
    checks++;
    if (dealt !== DECK) $display("FAIL b2b_count got %0d want %0d", dealt, DECK);
    else passes++;
    checks++;
    if (bad_card !== 0) $display("FAIL b2b_card_mismatches got %0d want 0", bad_card);
    else passes++;
    checks++;
    if (bad_max !== 0) $display("FAIL b2b_rng_max_mismatches got %0d want 0", bad_max);
    else passes++;
    dup = 0;
    for (int i = 0; i < DECK; i++) if (seen[i] != 1) dup++;
    checks++;
    if (dup !== 0) $display("FAIL b2b_unique_codes bad=%0d want 0", dup);
    else passes++;
    noise = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rng_next || deal_valid || busy) noise++;
    end
    deal_req = 1'b0;
    checks++;
    if (empty !== 1'b1 || cards_left !== 6'd0)
      $display("FAIL empty_flag empty=%0b left=%0d want 1/0", empty, cards_left);
    else passes++;
    checks++;
    if (noise !== 0) $display("FAIL deal_on_empty activity got %0d want 0", noise);
    else passes++;
  endtask

  task automatic test_shuffle_abort();
    int n = 0;
    int valids = 0;
    shuffle_start = 1'b1;
    tick();
    shuffle_start = 1'b0;
    wait_init("pre_abort_init");
    rng_int = 16'd3;
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    tick();
    tick();
    shuffle_start = 1'b1;
    deal_req = 1'b1;
    tick();
    shuffle_start = 1'b0;
    deal_req = 1'b0;
    checks++;
    if (busy !== 1'b1 || cards_left !== 6'd0 || deal_valid !== 1'b0)
      $display("FAIL abort_state busy=%0b left=%0d v=%0b want 1/0/0", busy, cards_left,
               deal_valid);
    else passes++;
    while (busy && n < 200) begin
      tick();
      n++;
      if (deal_valid) valids++;
    end
    checks++;
    if (n !== DECK || valids !== 0)
      $display("FAIL abort_reinit edges=%0d valids=%0d want %0d/0", n, valids, DECK);
    else passes++;
    model_fill();
    do_deal(51, "identity_top");
    do_deal(0, "identity_zero");
    do_deal(int'($urandom_range(0, 49)), "identity_rand");
  endtask

  task automatic test_reset_mid();
    deal_req = 1'b1;
    rng_int = 16'd7;
    tick();
    deal_req = 1'b0;
    tick();
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || empty !== 1'b1 || cards_left !== 6'd0 || card !== 6'd0 ||
        deal_valid !== 1'b0 || rng_next !== 1'b0)
      $display("FAIL reset_mid busy=%0b empty=%0b left=%0d card=%0d v=%0b nx=%0b want 1/1/0/0/0/0",
               busy, empty, cards_left, card, deal_valid, rng_next);
    else passes++;
    tick();
    reset = 1'b0;
    wait_init("reset_mid_init");
    do_deal(int'($urandom_range(0, 51)), "post_reset_deal");
  endtask

  initial begin
    test_reset();
    test_fixed_deal();
    test_back_to_back();
    test_shuffle_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
# card_dealer

Deals cards from a 52-card deck without repetition, one card per request, using a swap-and-shrink (Fisher–Yates) draw. Sits directly downstream of the RNG block: it pulses the RNG's `next_int`, drives its `max_n` with the remaining-card count (`min_n` tied to 0), and consumes `rand_int` as the draw index. Dealt cards go to the game/cursor logic.

## Interface
- `DECK_SIZE`, default 52: number of cards; card codes are 0..DECK_SIZE-1.
- `CARD_W`, default 6: card code and count width.
- `RNG_LAT`, default 2: wait cycles between the `rng_next` pulse and sampling `rng_int`.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `shuffle_start` input 1: restore the full deck; level-sampled each edge.
- `deal_req` input 1: request one card; sampled only in IDLE.
- `rng_int` input 16: random value from the RNG, in [0, `rng_max`).
- `rng_next` output 1: to RNG `next_int`; one-cycle registered pulse per draw.
- `rng_max` output 16: to RNG `max_n`; equals `cards_left`, zero-extended.
- `deal_valid` output 1: one-cycle pulse; `card` is valid while it is high.
- `card` output CARD_W: dealt card; suit = card/13, rank = card%13.
- `cards_left` output CARD_W: cards remaining in the deck.
- `empty` output 1: high when `cards_left`==0.
- `busy` output 1: high in any state other than IDLE.

## Operation
- Deck storage: DECK_SIZE × CARD_W array `deck[]`. Live cards occupy indices 0..`cards_left`-1. `top` = `cards_left`-1.
- States:
  - INIT: writes `deck[i]=i` for one index per cycle, i = 0..DECK_SIZE-1, over DECK_SIZE cycles. `cards_left` is held at 0 during INIT. On exit, `cards_left`=DECK_SIZE and the state goes to IDLE.
  - IDLE:
    - `shuffle_start` → INIT.
    - Otherwise, `deal_req` with `cards_left`>0 → REQ.
    - `deal_req` with `cards_left`==0 is ignored: no pulse, no state change.
  - REQ: holds `rng_next`=1 for exactly one cycle, then goes to WAIT.
  - WAIT: counts RNG_LAT cycles with `rng_next`=0, then goes to SWAP.
  - SWAP:
    - `idx` = `rng_int` if `rng_int` < `cards_left`; otherwise `idx` = `top` (out-of-range clamp).
    - Same edge: `card`<=`deck[idx]`; `deck[idx]`<=`deck[top]`; `cards_left`<=`cards_left`-1; `deal_valid`<=1; state → IDLE.
    - `idx`==`top` is legal and is a self-write.
- `shuffle_start` in any state aborts the current draw, with no `deal_valid`, and enters INIT, restarting at index 0. `shuffle_start` wins over a simultaneous `deal_req`.
- `deal_req` while busy is dropped; it is not queued.
- `empty` and `busy` are registered, consistent with the state and `cards_left`.

## Timing
- Reset values:
  - state INIT, index 0
  - `cards_left`=0, `empty`=1, `busy`=1
  - `card`=0, `deal_valid`=0, `rng_next`=0
- Reset asserted mid-operation: immediate return to these values. Any in-flight draw is lost.
- Init latency: `busy` falls DECK_SIZE cycles after reset deasserts.
- Deal latency, counting edge E0 as the edge that samples `deal_req` in IDLE:
  - `rng_next` is high during the cycle after E0.
  - `rng_int` is sampled at edge E0+RNG_LAT+2.
  - `deal_valid`, the new `card`, and the decremented `cards_left` are visible after that same edge.
  - Default RNG_LAT=2: 4 edges from request to valid.
- Back-to-back: a `deal_req` held high during the `deal_valid` cycle is accepted, because the state is IDLE. `rng_next` therefore returns low for at least RNG_LAT+1 cycles between pulses, which guarantees that the RNG sees a fresh rising edge.
- `rng_max` is stable from REQ through SWAP. It changes only at the SWAP edge and at INIT exit.
- `card` holds its last value between `deal_valid` pulses.

## Structure
- Package `card_pkg`:
  - DECK_SIZE, CARD_W, RNG_LAT defaults.
  - Ranks-per-suit constant (13) and suit/rank decode functions.
  - State enum {INIT, IDLE, REQ, WAIT, SWAP}.
- Sub-module `deck_store`: DECK_SIZE × CARD_W register file. It has two combinational read ports (`idx`, `top`) and one synchronous write port. It has no reset; INIT provides the contents.
- The top-level contains the FSM, the WAIT counter, the INIT index, the `idx` clamp, and the output registers.

## Test plan
- Reset released → `busy` falls after 52 cycles with `cards_left`=52, `empty`=0. No `rng_next` and no `deal_valid` occur during INIT.
- `deal_req` with `rng_int` forced to 5 → exactly one `rng_next` pulse. `deal_valid` 4 edges later with `card`=5 and `cards_left`=51. A second deal with `rng_int`=5 → `card`=51.
- With 51 cards left, `rng_int` forced to 60 (out of range) → clamp to `top`: `card`=`deck[50]`=50, `cards_left`=50.
- 52 back-to-back deals driven by an RNG model → every code 0..51 dealt exactly once, and `rng_max` tracks 52→1. Then `empty`=1, and a 53rd `deal_req` gives no `rng_next` and no `deal_valid`.
- `shuffle_start` asserted during WAIT → no `deal_valid`; INIT restarts. After 52 cycles, `cards_left`=52 and the deck is the identity. A simultaneous `deal_req` is ignored.
- `reset` asserted during SWAP → all outputs go to their reset values immediately, and the full INIT sequence reruns.
